avalon_cfg_writer: RTL and testbench
====================================

// Module: avalon_cfg_writer
// PURPOSE
//   Avalon-MM write initiator for the video control bus (scaler/mixer/video decode
//   window). Buffers (address,data) register writes from a config source in a FIFO.
//   Drains them in order as single-beat Avalon writes, honouring waitrequest.
//   Sits between the config source and the control-bus combiner.
// PARAMETERS
//   DEPTH    16    command FIFO entries; power of 2, >=2
//   AW       9     Avalon word-address width (bit 8 = video, bits 8:7 = 00 scaler / 01 mixer)
//   DW       32    write data width
//   TIMEOUT  1023  max stalled cycles per write; used only with AVL_TIMEOUT_EN
// PORTS
//   clk          in   1   clock; all logic on rising edge
//   rst          in   1   synchronous reset, active-high
//   cmd_valid    in   1   command offered
//   cmd_ready    out  1   FIFO can accept (count < DEPTH)
//   cmd_addr     in   AW  target register address
//   cmd_data     in   DW  target register data
//   idle         out  1   FIFO empty and no write in flight
//   err          out  1   sticky timeout flag (0 when AVL_TIMEOUT_EN undefined)
//   err_clr      in   1   clears err
//   address      out  AW  Avalon address
//   write        out  1   Avalon write strobe
//   writedata    out  DW  Avalon write data
//   waitrequest  in   1   Avalon stall from slave
// BEHAVIOUR
//   - Reset: write=0, address=0, writedata=0, FIFO count=0, cmd_ready=1, idle=1, err=0.
//     Reset mid-transfer abandons the in-flight write (write=0 next cycle) and drops all queued commands.
//   - Push when cmd_valid & cmd_ready. cmd_ready depends only on count, not on a same-cycle pop.
//     When full, a simultaneous pop does not allow a push that cycle.
//   - FSM IDLE: if FIFO non-empty, load head into address/writedata, set write=1, go BUSY.
//     Latency is one cycle: a push into an empty FIFO at edge N gives write=1 after edge N+1.
//   - FSM BUSY: address, writedata and write are held stable while waitrequest=1.
//     A cycle with write=1 & waitrequest=0 completes the transfer and pops the FIFO head.
//     If another entry remains after the pop, the next edge loads it with write kept at 1 (back-to-back).
//     Otherwise the next edge sets write=0 and returns to IDLE.
//   - Outputs address, write and writedata are registered. Write order equals push order.
//     Every command produces exactly one completed write (except on timeout abort or reset).
//   - idle = (count==0) & ~write; combinational from registered state.
//   - FIFO pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
//   - Simultaneous push and pop when neither full nor empty: count is unchanged.
// CONFIGURATION
//   AVL_TIMEOUT_EN defined:
//     - A stall counter resets on each new write and increments each cycle of write & waitrequest.
//     - When it reaches TIMEOUT with waitrequest still 1, the write is aborted: the entry is popped,
//       err is set, and the FSM continues with the next entry or returns to IDLE.
//     - err clears on err_clr; set has priority if both occur in the same cycle.
//   AVL_TIMEOUT_EN undefined:
//     - No counter. The block waits on waitrequest indefinitely; err is tied 0 and err_clr is ignored.
// TESTING
//   1 Push (0x081,0xDEADBEEF) with waitrequest=0 -> write=1 for exactly 1 cycle, address=0x081,
//     writedata=0xDEADBEEF, one cycle after push; idle=1 after.
//   2 Push 3 cmds, waitrequest=1 for 5 cycles on the first -> address/data stable 6 cycles, then 3
//     writes in push order, write held high across back-to-back transfers.
//   3 Push 16 cmds with waitrequest=1 -> cmd_ready=0 after 16th; 17th offer not accepted; releasing
//     waitrequest drains exactly 16 writes.
//   4 Assert rst during a stalled write with 4 queued -> write=0 next cycle, idle=1, no further writes.
//   5 (AVL_TIMEOUT_EN, TIMEOUT=8) Hold waitrequest=1 -> abort after 8 stall cycles, err=1, next cmd
//     issued; err_clr -> err=0.
//   6 Alternate push/pop at steady state for 100 cycles -> count constant, no lost or duplicated writes.

Source files
------------

// File: rtl/avalon_cfg_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : avalon_cfg_writer_if
// Brief   : Config-command and Avalon-MM write bundle for avalon_cfg_writer.
// Revision: 1.0
// ============================================================================
interface avalon_cfg_writer_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          idle;
    logic          err;
    logic          err_clr;
    logic [AW-1:0] address;
    logic          write;
    logic [DW-1:0] writedata;
    logic          waitrequest;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, err_clr, waitrequest,
        output cmd_ready, idle, err, address, write, writedata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, err_clr, waitrequest,
        input  cmd_ready, idle, err, address, write, writedata
    );
endinterface
`default_nettype wire

// File: rtl/avalon_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module  : avalon_cfg_writer
// Brief   : FIFO-buffered Avalon-MM single-beat register write initiator.
//           Optional stall timeout with sticky err when AVL_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
module avalon_cfg_writer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  wire logic             clk,
    input  wire logic             rst,
    avalon_cfg_writer_if.master   bus
);

    localparam int                c_PW       = $clog2(DEPTH);
    localparam logic [c_PW:0]     c_FULL     = (c_PW+1)'(DEPTH);
    localparam logic [c_PW:0]     c_CNT_ONE  = (c_PW+1)'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    logic [AW-1:0]   r_mem_addr [DEPTH];
    logic [DW-1:0]   r_mem_data [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW:0]   r_count;
    state_t          r_state;
    logic [AW-1:0]   r_address;
    logic [DW-1:0]   r_writedata;
    logic            r_write;

    state_t          w_state_nxt;
    logic            w_write_nxt;
    logic            w_load;
    logic [c_PW-1:0] w_load_ptr;
    logic            w_full;
    logic            w_push;
    logic            w_done;
    logic            w_abort;
    logic            w_pop;

    // Full is judged on count alone so a same-cycle pop never opens a slot.
    assign w_full = (r_count == c_FULL);
    assign w_push = bus.cmd_valid & ~w_full;
    assign w_done = r_write & ~bus.waitrequest;
    assign w_pop  = w_done | w_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_write_nxt = r_write;
        w_load      = 1'b0;
        w_load_ptr  = r_rd_ptr;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_load      = 1'b1;
                    w_write_nxt = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_pop) begin
                    // The head stays in the FIFO until popped, so the follower sits at rd_ptr+1.
                    if (r_count > c_CNT_ONE) begin
                        w_load     = 1'b1;
                        w_load_ptr = r_rd_ptr + 1'b1;
                    end else begin
                        w_write_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_write_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_write <= w_write_nxt;
            if (w_load) begin
                r_address   <= r_mem_addr[w_load_ptr];
                r_writedata <= r_mem_data[w_load_ptr];
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= bus.cmd_addr;
            r_mem_data[r_wr_ptr] <= bus.cmd_data;
        end
    end

`ifdef AVL_TIMEOUT_EN
    localparam int c_SW = $clog2(TIMEOUT + 1);

    logic [c_SW-1:0] r_stall;
    logic            r_err;

    // Abort on the TIMEOUT-th consecutive stalled cycle of the current write.
    assign w_abort = r_write & bus.waitrequest & (r_stall == c_SW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_load)
                r_stall <= '0;
            else if (r_write & bus.waitrequest)
                r_stall <= r_stall + 1'b1;
            if (w_abort)
                r_err <= 1'b1;
            else if (bus.err_clr)
                r_err <= 1'b0;
        end
    end

    assign bus.err = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = bus.err_clr;
    assign w_abort          = 1'b0;
    assign bus.err          = 1'b0;
`endif

    assign bus.cmd_ready = ~w_full;
    assign bus.idle      = (r_count == '0) & ~r_write;
    assign bus.address   = r_address;
    assign bus.write     = r_write;
    assign bus.writedata = r_writedata;

endmodule
`default_nettype wire

// File: tb/tb_avalon_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_avalon_cfg_writer
// Brief   : Self-checking bench: vector table, directed corner sequences and
//           randomized traffic against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_avalon_cfg_writer;

    localparam int DEPTH = 16;
    localparam int AW    = 9;
    localparam int DW    = 32;
`ifdef AVL_TIMEOUT_EN
    localparam int TMO   = 8;
`else
    localparam int TMO   = 1023;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avalon_cfg_writer_if #(.AW(AW), .DW(DW)) bus ();

    avalon_cfg_writer #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            stall;
        int            exp_hold;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    cmd_t tx_q[$];
    cmd_t model_q[$];
    logic [AW-1:0] comp_a[$];
    logic [DW-1:0] comp_d[$];
    bit   mon_en   = 1'b0;
    int   n_pushed = 0;
    int   n_done   = 0;
    cmd_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the FIFO is a plain queue; a write completes whenever
    // write & ~waitrequest is seen before an edge and must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
        end else if (mon_en) begin
            check("mon_ready", {63'd0, bus.cmd_ready}, {63'd0, model_q.size() < DEPTH});
            check("mon_idle",  {63'd0, bus.idle},      {63'd0, model_q.size() == 0});
            if (bus.write && !bus.waitrequest) begin
                if (model_q.size() == 0) begin
                    check("mon_spurious_write", 64'd1, 64'd0);
                end else begin
                    mon_e = model_q.pop_front();
                    check("mon_addr", 64'(bus.address),   64'(mon_e.a));
                    check("mon_data", 64'(bus.writedata), 64'(mon_e.d));
                    n_done++;
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                model_q.push_back('{a: bus.cmd_addr, d: bus.cmd_data});
                n_pushed++;
            end
        end
    end

    // Drives pushes from tx_q and stalls the first 'stall' write-high cycles.
    task automatic run(input int stall, input int ncmd, output int hold0,
                       output int lat, output int nhigh, output bit gap);
        int  done = 0;
        int  cyc  = 0;
        bit  seen = 1'b0;
        bit  acc;
        hold0 = 0; lat = -1; nhigh = 0; gap = 1'b0;
        comp_a.delete();
        comp_d.delete();
        while (done < ncmd && cyc < 300) begin
            if (tx_q.size() > 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = tx_q[0].a;
                bus.cmd_data  = tx_q[0].d;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            acc = bus.cmd_valid && bus.cmd_ready;
            if (bus.write) begin
                if (!seen) lat = cyc;
                seen            = 1'b1;
                bus.waitrequest = (nhigh < stall);
                if (done == 0) hold0++;
                nhigh++;
                if (!bus.waitrequest) begin
                    comp_a.push_back(bus.address);
                    comp_d.push_back(bus.writedata);
                    done++;
                end
            end else begin
                bus.waitrequest = 1'b0;
                if (seen) gap = 1'b1;
            end
            tick();
            if (acc) void'(tx_q.pop_front());
            cyc++;
        end
        bus.cmd_valid   = 1'b0;
        bus.waitrequest = 1'b0;
        check("run_completions", 64'(done), 64'(ncmd));
    endtask

    task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        check("push_ready", {63'd0, bus.cmd_ready}, 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    vec_t vecs[4];
    int   hold0, lat, nhigh, cnt, streak, d0;
    bit   gap;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{addr: 9'h081, data: 32'hDEADBEEF, stall: 0, exp_hold: 1};
        vecs[1] = '{addr: 9'h1FF, data: 32'hFFFFFFFF, stall: 3, exp_hold: 4};
        vecs[2] = '{addr: 9'h000, data: 32'h00000000, stall: 1, exp_hold: 2};
        vecs[3] = '{addr: 9'h100, data: 32'hA5A55A5A, stall: 6, exp_hold: 7};

        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.err_clr = 1'b0; bus.waitrequest = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_write",     {63'd0, bus.write},     64'd0);
        check("rst_address",   64'(bus.address),       64'd0);
        check("rst_writedata", 64'(bus.writedata),     64'd0);
        check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        check("rst_idle",      {63'd0, bus.idle},      64'd1);
        check("rst_err",       {63'd0, bus.err},       64'd0);
        rst = 1'b0;
        tick();

        // Single-command vectors: latency, hold under stall, payload, return to idle
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back('{a: vecs[i].addr, d: vecs[i].data});
            run(vecs[i].stall, 1, hold0, lat, nhigh, gap);
            check($sformatf("vec%0d_latency", i), 64'(lat),   64'd2);
            check($sformatf("vec%0d_hold", i),    64'(hold0), 64'(vecs[i].exp_hold));
            check($sformatf("vec%0d_addr", i),    64'(comp_a[0]), 64'(vecs[i].addr));
            check($sformatf("vec%0d_data", i),    64'(comp_d[0]), 64'(vecs[i].data));
            check($sformatf("vec%0d_write_low", i), {63'd0, bus.write}, 64'd0);
            check($sformatf("vec%0d_idle", i),    {63'd0, bus.idle},  64'd1);
            tick();
        end

        // Three queued commands, first stalled 5 cycles, rest back-to-back
        tx_q.push_back('{a: 9'h001, d: 32'h11111111});
        tx_q.push_back('{a: 9'h080, d: 32'h22222222});
        tx_q.push_back('{a: 9'h180, d: 32'h33333333});
        run(5, 3, hold0, lat, nhigh, gap);
        check("b2b_hold_first", 64'(hold0), 64'd6);
        check("b2b_write_cycles", 64'(nhigh), 64'd8);
        check("b2b_no_gap", {63'd0, gap}, 64'd0);
        check("b2b_order0", 64'(comp_a[0]), 64'h001);
        check("b2b_order1", 64'(comp_a[1]), 64'h080);
        check("b2b_order2", 64'(comp_a[2]), 64'h180);
        check("b2b_data2",  64'(comp_d[2]), 64'h33333333);
        check("b2b_idle",   {63'd0, bus.idle}, 64'd1);

`ifndef AVL_TIMEOUT_EN
        // Fill to DEPTH under stall; full FIFO refuses a push even on a pop cycle
        bus.waitrequest = 1'b1;
        for (int i = 0; i < DEPTH; i++) push1(AW'(i), 32'hC0DE0000 + i);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 9'h1AA;
        bus.cmd_data  = 32'hBAD0BAD0;
        check("full_ready0", {63'd0, bus.cmd_ready}, 64'd0);
        tick();
        check("full_ready1", {63'd0, bus.cmd_ready}, 64'd0);
        bus.waitrequest = 1'b0;
        check("full_head_addr", 64'(bus.address), 64'd0);
        check("full_head_write", {63'd0, bus.write}, 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
        run(0, DEPTH - 1, hold0, lat, nhigh, gap);
        cnt = 0;
        for (int i = 0; i < DEPTH - 1; i++) if (comp_a[i] !== AW'(i + 1)) cnt++;
        check("full_drain_order", 64'(cnt), 64'd0);
        tick(); tick();
        check("full_no_extra_write", {63'd0, bus.write}, 64'd0);
        check("full_idle", {63'd0, bus.idle}, 64'd1);
`endif

        // Reset during a stalled write with more queued
        bus.waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) push1(AW'(9'h040 + i), 32'h40400000 + i);
        tick();
        check("rstmid_write_before", {63'd0, bus.write}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_write", {63'd0, bus.write}, 64'd0);
        check("rstmid_idle", {63'd0, bus.idle}, 64'd1);
        check("rstmid_ready", {63'd0, bus.cmd_ready}, 64'd1);
        check("rstmid_addr", 64'(bus.address), 64'd0);
        bus.waitrequest = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.write) cnt++;
        end
        check("rstmid_no_writes", 64'(cnt), 64'd0);

`ifdef AVL_TIMEOUT_EN
        // Timeout abort, sticky err, then clear
        bus.waitrequest = 1'b1;
        push1(9'h0A1, 32'h0A0A0A0A);
        push1(9'h0A2, 32'h0B0B0B0B);
        cnt = 0;
        while (bus.write && bus.address == 9'h0A1 && cnt < 50) begin
            cnt++;
            tick();
        end
        check("tmo_stall_cycles", 64'(cnt), 64'(TMO));
        check("tmo_next_write", {63'd0, bus.write}, 64'd1);
        check("tmo_next_addr", 64'(bus.address), 64'h0A2);
        check("tmo_err_set", {63'd0, bus.err}, 64'd1);
        bus.waitrequest = 1'b0;
        tick();
        check("tmo_drained", {63'd0, bus.write}, 64'd0);
        check("tmo_err_sticky", {63'd0, bus.err}, 64'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("tmo_err_clr", {63'd0, bus.err}, 64'd0);
`else
        // No timeout: a long stall is held indefinitely and err stays 0
        bus.waitrequest = 1'b1;
        push1(9'h0A1, 32'h0A0A0A0A);
        tick();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.write && bus.address == 9'h0A1) cnt++;
            tick();
        end
        check("notmo_held", 64'(cnt), 64'd30);
        check("notmo_err", {63'd0, bus.err}, 64'd0);
        bus.waitrequest = 1'b0;
        bus.err_clr     = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("notmo_err_after_clr", {63'd0, bus.err}, 64'd0);
        check("notmo_done", {63'd0, bus.write}, 64'd0);
        check("notmo_idle", {63'd0, bus.idle}, 64'd1);
`endif

        // Steady state: one push and one completion per cycle
        do_reset();
        mon_en = 1'b1;
        bus.waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) push1(AW'(9'h020 + i), 32'h5A000000 + i);
        d0 = n_done;
        bus.waitrequest = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_addr  = AW'($urandom);
            bus.cmd_data  = $urandom;
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("steady_completions", 64'(n_done - d0), 64'd100);
        check("steady_depth", 64'(model_q.size()), 64'd4);

        // Randomized traffic with stall bursts shorter than any timeout
        streak = 0;
        for (int i = 0; i < 800; i++) begin
            bus.cmd_valid = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
            bus.cmd_addr  = AW'($urandom);
            bus.cmd_data  = $urandom;
            if (streak >= 3) bus.waitrequest = 1'b0;
            else             bus.waitrequest = ($urandom_range(0, 2) == 0);
            streak = bus.waitrequest ? streak + 1 : 0;
            tick();
        end
        bus.cmd_valid   = 1'b0;
        bus.waitrequest = 1'b0;
        cnt = 0;
        while (!bus.idle && cnt < 200) begin
            tick();
            cnt++;
        end
        tick();
        check("rand_drain_idle", {63'd0, bus.idle}, 64'd1);
        check("rand_model_empty", 64'(model_q.size()), 64'd0);
        check("rand_push_eq_done", 64'(n_pushed), 64'(n_done));
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
